// File: rtl/binarize_pkg.sv
// Shared types and constants for the adaptive binarizer: FSM state encoding
// and the frame-mean reset value.
package binarize_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIV    = 2'd1,
        ST_UPDATE = 2'd2
    } state_e;

    // Mid-grey for a given pixel width: 2^(dw-1).
    function automatic int unsigned mean_rst_val(input int unsigned dw);
        return 32'd1 << (dw - 32'd1);
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle; the quotient is
// final on the cycle done pulses.
module seq_divider #(
    parameter int unsigned NW  = 30,
    parameter int unsigned DSW = 22
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [NW-1:0]  dividend,
    input  logic [DSW-1:0] divisor,
    output logic           busy,
    output logic           done,
    output logic [NW-1:0]  quotient
);

    localparam int unsigned CW = $clog2(NW + 1);

    logic [NW-1:0]  quo_q, quo_d;
    logic [DSW-1:0] rem_q, rem_d;
    logic [DSW-1:0] dsr_q, dsr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [DSW:0]   shifted_c;
    logic [DSW:0]   trial_c;

    always_comb begin
        quo_d     = quo_q;
        rem_d     = rem_q;
        dsr_d     = dsr_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        shifted_c = {rem_q, quo_q[NW-1]};
        trial_c   = shifted_c - {1'b0, dsr_q};
        if (start) begin
            quo_d  = dividend;
            rem_d  = '0;
            dsr_d  = divisor;
            cnt_d  = CW'(NW);
            busy_d = 1'b1;
        end else if (busy_q) begin
            // Keep the trial difference only when it did not go negative.
            if (shifted_c >= {1'b0, dsr_q}) begin
                rem_d = trial_c[DSW-1:0];
                quo_d = {quo_q[NW-2:0], 1'b1};
            end else begin
                rem_d = shifted_c[DSW-1:0];
                quo_d = {quo_q[NW-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dsr_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dsr_q  <= dsr_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign quotient = quo_q;

endmodule

// File: rtl/image_binarize_adaptive.sv
// Hysteresis binarizer with per-line edge summary and a previous-frame mean
// that can serve as the threshold centre.
module image_binarize_adaptive
    import binarize_pkg::*;
#(
    parameter int unsigned DW     = 8,
    parameter int unsigned COLW   = 11,
    parameter int unsigned CNTW   = 22,
    parameter bit          VS_POL = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pre_frame_vsync,
    input  logic            pre_frame_hsync,
    input  logic            pre_frame_de,
    input  logic [DW-1:0]   pixel,
    input  logic [DW-1:0]   thr,
    input  logic [DW-1:0]   hyst,
    input  logic            adaptive,
    output logic            post_frame_vsync,
    output logic            post_frame_hsync,
    output logic            post_frame_de,
    output logic            monoc,
    output logic            monoc_rise,
    output logic            monoc_fall,
    output logic [DW-1:0]   pixel_out,
    output logic            line_valid,
    output logic [COLW-1:0] first_rise_col,
    output logic [COLW-1:0] last_fall_col,
    output logic [COLW-1:0] edge_cnt,
    output logic [DW-1:0]   frame_mean,
    output logic            mean_valid,
    output logic            mean_drop
);

    localparam int unsigned SW       = DW + CNTW;
    localparam int unsigned DCW      = $clog2(SW + 1);
    localparam logic [DW-1:0]   MEAN_RST = DW'(mean_rst_val(DW));
    localparam logic [COLW-1:0] COL_MAX  = {COLW{1'b1}};
    localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};

    logic            vs_q, vs_d, hs_q, hs_d, de_q, de_d;
    logic            monoc_q, monoc_d, rise_q, rise_d, fall_q, fall_d;
    logic [COLW-1:0] col_q, col_d;
    logic [COLW-1:0] run_first_q, run_first_d, run_last_q, run_last_d;
    logic [COLW-1:0] run_cnt_q, run_cnt_d;
    logic            line_end_q, line_end_d, line_valid_q, line_valid_d;
    logic [COLW-1:0] first_q, first_d, last_q, last_d, ecnt_q, ecnt_d;
    logic [SW-1:0]   sum_q, sum_d;
    logic [CNTW-1:0] acc_cnt_q, acc_cnt_d;
    logic            mean_drop_q, mean_drop_d;

    logic            de_rise_c, de_fall_c, white_c, frame_end_c, div_start_c;
    logic [DW-1:0]   centre_c, lo_c, mean_sat_c;
    logic [COLW-1:0] col_inc_c, col_cur_c;
    logic [COLW-1:0] run_first_b, run_last_b, run_cnt_b;

    state_e          state_q;
    logic [DCW-1:0]  div_cyc_q;
    logic [DW-1:0]   frame_mean_q;
    logic            mean_valid_q;
    logic            div_busy, div_done;
    logic [SW-1:0]   div_quo;

    // Pixel path, line summary and frame accumulators.
    always_comb begin
        vs_d = pre_frame_vsync;
        hs_d = pre_frame_hsync;
        de_d = pre_frame_de;

        de_rise_c = pre_frame_de & ~de_q;
        de_fall_c = ~pre_frame_de & de_q;
        centre_c  = adaptive ? frame_mean_q : thr;
        lo_c      = (centre_c > hyst) ? (centre_c - hyst) : '0;
        // A new line always starts from black, so prior state only counts while de was high.
        white_c   = (de_q & monoc_q) ? (pixel < centre_c) : (pixel < lo_c);
        monoc_d   = pre_frame_de & white_c;
        rise_d    = monoc_d & ~monoc_q;
        fall_d    = ~monoc_d & monoc_q;

        col_inc_c = (col_q == COL_MAX) ? col_q : (col_q + COLW'(1));
        col_cur_c = de_rise_c ? '0 : col_inc_c;
        col_d     = pre_frame_de ? col_cur_c : col_q;

        run_first_b = de_rise_c ? COL_MAX : run_first_q;
        run_last_b  = de_rise_c ? COL_MAX : run_last_q;
        run_cnt_b   = de_rise_c ? '0 : run_cnt_q;
        run_first_d = run_first_b;
        run_last_d  = run_last_b;
        run_cnt_d   = run_cnt_b;
        if (rise_d) begin
            if (run_cnt_b == '0) begin
                run_first_d = col_cur_c;
            end
            if (run_cnt_b != COL_MAX) begin
                run_cnt_d = run_cnt_b + COLW'(1);
            end
        end
        if (fall_d) begin
            run_last_d = col_cur_c;
        end

        line_end_d   = de_fall_c;
        line_valid_d = line_end_q;
        first_d      = first_q;
        last_d       = last_q;
        ecnt_d       = ecnt_q;
        if (line_end_q) begin
            first_d = run_first_q;
            last_d  = run_last_q;
            ecnt_d  = run_cnt_q;
        end

        frame_end_c = (pre_frame_vsync == VS_POL) && (vs_q != VS_POL);
        sum_d       = sum_q;
        acc_cnt_d   = acc_cnt_q;
        if (frame_end_c) begin
            sum_d     = pre_frame_de ? SW'(pixel) : '0;
            acc_cnt_d = pre_frame_de ? CNTW'(1) : '0;
        end else if (pre_frame_de && (acc_cnt_q != CNT_MAX)) begin
            sum_d     = sum_q + SW'(pixel);
            acc_cnt_d = acc_cnt_q + CNTW'(1);
        end
        mean_drop_d = frame_end_c && (state_q != ST_IDLE);
        div_start_c = frame_end_c && (state_q == ST_IDLE) && (acc_cnt_q != '0) && !div_busy;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_q         <= 1'b0;
            hs_q         <= 1'b0;
            de_q         <= 1'b0;
            monoc_q      <= 1'b0;
            rise_q       <= 1'b0;
            fall_q       <= 1'b0;
            col_q        <= '0;
            run_first_q  <= COL_MAX;
            run_last_q   <= COL_MAX;
            run_cnt_q    <= '0;
            line_end_q   <= 1'b0;
            line_valid_q <= 1'b0;
            first_q      <= COL_MAX;
            last_q       <= COL_MAX;
            ecnt_q       <= '0;
            sum_q        <= '0;
            acc_cnt_q    <= '0;
            mean_drop_q  <= 1'b0;
        end else begin
            vs_q         <= vs_d;
            hs_q         <= hs_d;
            de_q         <= de_d;
            monoc_q      <= monoc_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            col_q        <= col_d;
            run_first_q  <= run_first_d;
            run_last_q   <= run_last_d;
            run_cnt_q    <= run_cnt_d;
            line_end_q   <= line_end_d;
            line_valid_q <= line_valid_d;
            first_q      <= first_d;
            last_q       <= last_d;
            ecnt_q       <= ecnt_d;
            sum_q        <= sum_d;
            acc_cnt_q    <= acc_cnt_d;
            mean_drop_q  <= mean_drop_d;
        end
    end

    seq_divider #(
        .NW  (SW),
        .DSW (CNTW)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start_c),
        .dividend (sum_q),
        .divisor  (acc_cnt_q),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quo)
    );

    assign mean_sat_c = (|div_quo[SW-1:DW]) ? '1 : div_quo[DW-1:0];

    // Mean FSM: DIV spans exactly SW cycles, UPDATE publishes the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            div_cyc_q    <= '0;
            frame_mean_q <= MEAN_RST;
            mean_valid_q <= 1'b0;
        end else begin
            mean_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (div_start_c) begin
                        state_q   <= ST_DIV;
                        div_cyc_q <= DCW'(SW - 1);
                    end
                end
                ST_DIV: begin
                    if (div_cyc_q == '0) begin
                        state_q <= ST_UPDATE;
                    end else begin
                        div_cyc_q <= div_cyc_q - DCW'(1);
                    end
                end
                ST_UPDATE: begin
                    if (div_done) begin
                        frame_mean_q <= mean_sat_c;
                        mean_valid_q <= 1'b1;
                    end
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign post_frame_vsync = vs_q;
    assign post_frame_hsync = hs_q;
    assign post_frame_de    = de_q;
    assign monoc            = monoc_q;
    assign monoc_rise       = rise_q;
    assign monoc_fall       = fall_q;
    assign pixel_out        = {DW{monoc_q & de_q}};
    assign line_valid       = line_valid_q;
    assign first_rise_col   = first_q;
    assign last_fall_col    = last_q;
    assign edge_cnt         = ecnt_q;
    assign frame_mean       = frame_mean_q;
    assign mean_valid       = mean_valid_q;
    assign mean_drop        = mean_drop_q;

endmodule

// File: tb/tb_image_binarize_adaptive.sv
// Randomized bench for image_binarize_adaptive against a line/frame-level
// reference model.
module tb_image_binarize_adaptive;

    localparam int unsigned DW   = 8;
    localparam int unsigned COLW = 11;
    localparam int unsigned CNTW = 22;
    localparam int          ONES = 2047;

    logic            clk = 1'b0;
    logic            rst;
    logic            vsync, hsync, de, adaptive;
    logic [DW-1:0]   pixel, thr, hyst;
    logic            post_vsync, post_hsync, post_de;
    logic            monoc, monoc_rise, monoc_fall;
    logic [DW-1:0]   pixel_out;
    logic            line_valid;
    logic [COLW-1:0] first_rise_col, last_fall_col, edge_cnt;
    logic [DW-1:0]   frame_mean;
    logic            mean_valid, mean_drop;

    image_binarize_adaptive #(
        .DW(DW), .COLW(COLW), .CNTW(CNTW), .VS_POL(1'b1)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .pre_frame_vsync  (vsync),
        .pre_frame_hsync  (hsync),
        .pre_frame_de     (de),
        .pixel            (pixel),
        .thr              (thr),
        .hyst             (hyst),
        .adaptive         (adaptive),
        .post_frame_vsync (post_vsync),
        .post_frame_hsync (post_hsync),
        .post_frame_de    (post_de),
        .monoc            (monoc),
        .monoc_rise       (monoc_rise),
        .monoc_fall       (monoc_fall),
        .pixel_out        (pixel_out),
        .line_valid       (line_valid),
        .first_rise_col   (first_rise_col),
        .last_fall_col    (last_fall_col),
        .edge_cnt         (edge_cnt),
        .frame_mean       (frame_mean),
        .mean_valid       (mean_valid),
        .mean_drop        (mean_drop)
    );

    always #5 clk = ~clk;

    int     checks   = 0;
    int     failures = 0;
    int     cyc      = 0;
    int     model_mean = 128;
    longint model_sum  = 0;
    longint model_cnt  = 0;
    int     line_px [64];
    bit     line_ad [64];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Drive one line and check pixel-level and line-summary outputs.
    task automatic drive_line(input int n, input int thr_v, input int hyst_v, input string nm);
        int exp_m [65];
        int st;
        int first;
        int last;
        int ecnt;
        int centre;
        int lo;
        int prev;
        st = 0; first = -1; last = -1; ecnt = 0;
        for (int i = 0; i < n; i++) begin
            centre = line_ad[i] ? model_mean : thr_v;
            lo     = (centre > hyst_v) ? centre - hyst_v : 0;
            if (st == 0 && line_px[i] < lo) st = 1;
            else if (st == 1 && line_px[i] >= centre) st = 0;
            exp_m[i] = st;
        end
        exp_m[n] = 0;
        for (int i = 0; i <= n; i++) begin
            prev = (i == 0) ? 0 : exp_m[i-1];
            if (exp_m[i] == 1 && prev == 0) begin
                if (first < 0) first = i;
                ecnt++;
            end
            if (exp_m[i] == 0 && prev == 1) last = i;
        end
        thr  = 8'(thr_v);
        hyst = 8'(hyst_v);
        for (int i = 0; i < n; i++) begin
            de       = 1'b1;
            pixel    = 8'(line_px[i]);
            adaptive = line_ad[i];
            step();
            prev = (i == 0) ? 0 : exp_m[i-1];
            check_eq({nm, "_monoc"}, monoc, exp_m[i]);
            check_eq({nm, "_rise"}, monoc_rise, (exp_m[i] == 1 && prev == 0) ? 1 : 0);
            check_eq({nm, "_fall"}, monoc_fall, (exp_m[i] == 0 && prev == 1) ? 1 : 0);
            check_eq({nm, "_pixout"}, pixel_out, (exp_m[i] == 1) ? 255 : 0);
            check_eq({nm, "_post_de"}, post_de, 1);
            model_sum += line_px[i];
            model_cnt++;
        end
        de    = 1'b0;
        hsync = 1'b1;
        pixel = 8'($urandom_range(255, 0));
        step();
        hsync = 1'b0;
        check_eq({nm, "_monoc_off"}, monoc, 0);
        check_eq({nm, "_end_fall"}, monoc_fall, exp_m[n-1]);
        check_eq({nm, "_post_hs"}, post_hsync, 1);
        check_eq({nm, "_lv_early"}, line_valid, 0);
        step();
        check_eq({nm, "_lv"}, line_valid, 1);
        check_eq({nm, "_first"}, first_rise_col, (first < 0) ? ONES : first);
        check_eq({nm, "_last"}, last_fall_col, (last < 0) ? ONES : last);
        check_eq({nm, "_ecnt"}, edge_cnt, ecnt);
        step();
        check_eq({nm, "_lv_pulse"}, line_valid, 0);
    endtask

    task automatic frame_end(output int c0, output longint cs, output longint cc);
        vsync = 1'b1;
        step();
        c0 = cyc;
        vsync = 1'b0;
        check_eq("post_vsync", post_vsync, 1);
        cs = model_sum;
        cc = model_cnt;
        model_sum = 0;
        model_cnt = 0;
    endtask

    // Mean must appear DW+CNTW+2 cycles after the vsync cycle, not earlier.
    task automatic wait_mean(input int c0, input int exp_mean);
        int early;
        early = 0;
        while (cyc < c0 + 30) begin
            step();
            if (mean_valid) early++;
        end
        check_eq("mean_early", early, 0);
        step();
        check_eq("mean_valid", mean_valid, 1);
        check_eq("frame_mean", frame_mean, exp_mean);
        model_mean = exp_mean;
        step();
        check_eq("mean_valid_pulse", mean_valid, 0);
    endtask

    task automatic rand_lines(input int count, input bit use_ad, input string nm);
        int n;
        for (int l = 0; l < count; l++) begin
            n = $urandom_range(40, 4);
            for (int i = 0; i < n; i++) begin
                line_px[i] = $urandom_range(255, 0);
                line_ad[i] = use_ad ? 1'($urandom_range(1, 0)) : 1'b0;
            end
            drive_line(n, $urandom_range(255, 0), $urandom_range(60, 0), nm);
        end
    endtask

    initial begin
        int     c0;
        int     seen;
        int     drops;
        longint cs;
        longint cc;
        int     exp_mean;

        rst = 1'b1; vsync = 1'b0; hsync = 1'b0; de = 1'b0; adaptive = 1'b0;
        pixel = '0; thr = '0; hyst = '0;
        step();
        step();
        check_eq("rst_monoc", monoc, 0);
        check_eq("rst_pixout", pixel_out, 0);
        check_eq("rst_first", first_rise_col, ONES);
        check_eq("rst_last", last_fall_col, ONES);
        check_eq("rst_ecnt", edge_cnt, 0);
        check_eq("rst_mean", frame_mean, 128);
        check_eq("rst_mvalid", mean_valid, 0);
        check_eq("rst_mdrop", mean_drop, 0);
        check_eq("rst_lv", line_valid, 0);
        check_eq("rst_post_de", post_de, 0);
        rst = 1'b0;
        step();

        line_px[0] = 174; line_px[1] = 175; line_px[2] = 0;
        for (int i = 0; i < 3; i++) line_ad[i] = 1'b0;
        drive_line(3, 175, 0, "static");

        line_px[0] = 90; line_px[1] = 79; line_px[2] = 95; line_px[3] = 100;
        for (int i = 0; i < 4; i++) line_ad[i] = 1'b0;
        drive_line(4, 100, 20, "hyst");

        for (int i = 0; i < 16; i++) begin
            line_px[i] = ((i >= 3 && i <= 5) || i == 10) ? 20 : 200;
            line_ad[i] = 1'b0;
        end
        drive_line(16, 128, 0, "line16");
        check_eq("line16_first_lit", first_rise_col, 3);
        check_eq("line16_last_lit", last_fall_col, 11);
        check_eq("line16_ecnt_lit", edge_cnt, 2);

        for (int i = 0; i < 16; i++) line_px[i] = 200;
        drive_line(16, 128, 0, "black");

        rand_lines(20, 1'b0, "rnd");

        frame_end(c0, cs, cc);
        check_eq("mdrop_idle", mean_drop, 0);
        exp_mean = int'(cs / cc);
        if (exp_mean > 255) exp_mean = 255;
        wait_mean(c0, exp_mean);

        for (int l = 0; l < 4; l++) begin
            for (int i = 0; i < 4; i++) begin
                line_px[i] = 60;
                line_ad[i] = 1'b0;
            end
            drive_line(4, 128, 0, "px60");
        end
        frame_end(c0, cs, cc);
        wait_mean(c0, 60);
        check_eq("mean60_lit", frame_mean, 60);

        line_px[0] = 59; line_px[1] = 60; line_px[2] = 30; line_px[3] = 61;
        for (int i = 0; i < 4; i++) line_ad[i] = 1'b1;
        drive_line(4, 200, 0, "adapt");

        rand_lines(12, 1'b1, "rnd_ad");

        // Second frame end while the first mean is still being divided.
        frame_end(c0, cs, cc);
        exp_mean = int'(cs / cc);
        for (int i = 0; i < 4; i++) begin
            line_px[i] = $urandom_range(255, 0);
            line_ad[i] = 1'b0;
        end
        drive_line(4, 128, 10, "during_div");
        vsync = 1'b1;
        step();
        vsync = 1'b0;
        check_eq("mdrop", mean_drop, 1);
        model_sum = 0;
        model_cnt = 0;
        step();
        check_eq("mdrop_pulse", mean_drop, 0);
        wait_mean(c0, exp_mean);

        // Reset in the middle of a divide.
        rand_lines(2, 1'b0, "pre_rst");
        frame_end(c0, cs, cc);
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        step();
        check_eq("midrst_mean", frame_mean, 128);
        check_eq("midrst_mvalid", mean_valid, 0);
        check_eq("midrst_first", first_rise_col, ONES);
        rst = 1'b0;
        model_mean = 128;
        model_sum  = 0;
        model_cnt  = 0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (mean_valid) seen++;
        end
        check_eq("midrst_no_mean", seen, 0);
        check_eq("midrst_mean_hold", frame_mean, 128);

        // Empty frame: no divide, no mean update.
        frame_end(c0, cs, cc);
        seen = 0;
        drops = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (mean_valid) seen++;
            if (mean_drop) drops++;
        end
        check_eq("empty_no_mean", seen, 0);
        check_eq("empty_no_drop", drops, 0);

        rand_lines(4, 1'b1, "post_rst_ad");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
